// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight load, skewed activation streaming and result de-skew for an N x N weight-stationary array
module systolic_ctrl #(
  parameter int N = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    keep_w,
  input  logic [LEN_WIDTH-1:0]    m_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [N*DATA_WIDTH-1:0] w_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [N*DATA_WIDTH-1:0] a_data,
  output logic [N-1:0]            arr_load,
  output logic [N*DATA_WIDTH-1:0] arr_wt,
  output logic [N*DATA_WIDTH-1:0] arr_a,
  input  logic [N*ACC_WIDTH-1:0]  arr_b,
  output logic                    res_valid,
  output logic [N*ACC_WIDTH-1:0]  res_data
);
  localparam int RW = N > 1 ? $clog2(N) : 1;
  localparam int VD = 2 * N + 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t r_state, w_nxt;
  logic [RW-1:0] r_row;
  logic [LEN_WIDTH-1:0] r_len, r_cnt;
  logic [VD-1:0] r_vld;
  logic w_wacc, w_aacc, w_last;
  assign w_ready = r_state == LOAD_W;
  assign a_ready = r_state == STREAM && r_cnt < r_len;
  assign w_wacc = w_valid && w_ready;
  assign w_aacc = a_valid && a_ready;
  assign w_last = w_aacc && r_cnt + LEN_WIDTH'(1) == r_len;
  assign busy = r_state != IDLE && r_state != DONE;
  assign done = r_state == DONE;
  assign res_valid = r_vld[VD-1];
  // next state: a zero-length job leaves LOAD_W for DONE and passes straight through STREAM
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = start ? (keep_w ? STREAM : LOAD_W) : IDLE;
      LOAD_W:  w_nxt = (w_wacc && r_row == RW'(N - 1)) ? (r_len == '0 ? DONE : STREAM) : LOAD_W;
      STREAM:  w_nxt = (r_len == '0 || w_last) ? DRAIN : STREAM;
      DRAIN:   w_nxt = r_vld[VD-2:0] == '0 ? DONE : DRAIN;
      default: w_nxt = IDLE;
    endcase
  end
  // state, job length latch and the row / vector counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && start) begin
        r_len <= m_len;
        r_cnt <= '0;
        r_row <= '0;
      end
      if (w_wacc) r_row <= r_row + RW'(1);
      if (w_aacc) r_cnt <= r_cnt + LEN_WIDTH'(1);
    end
  end
  // weight row goes out one cycle after its handshake with a one-hot row strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_load <= '0;
      arr_wt <= '0;
    end else begin
      arr_load <= w_wacc ? N'(1) << r_row : '0;
      if (w_wacc) arr_wt <= w_data;
    end
  end
  // accept marker travels the full skew + array + de-skew latency to become res_valid
  always_ff @(posedge clk) begin
    if (rst) r_vld <= '0;
    else r_vld <= {r_vld[VD-2:0], w_aacc};
  end
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [(i+1)*DATA_WIDTH-1:0] r_sh;
    // row i delay line: element i on accept, zero bubble otherwise, emerging i+1 cycles later
    always_ff @(posedge clk) begin
      if (rst) r_sh <= '0;
      else begin
        r_sh <= r_sh << DATA_WIDTH;
        r_sh[DATA_WIDTH-1:0] <= w_aacc ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
    assign arr_a[i*DATA_WIDTH +: DATA_WIDTH] = r_sh[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH];
  end
  for (genvar j = 0; j < N; j++) begin : g_deskew
    logic [(N-j)*ACC_WIDTH-1:0] r_ds;
    // column j waits N-1-j cycles so one vector's columns line up, last stage is the output register
    always_ff @(posedge clk) begin
      if (rst) r_ds <= '0;
      else begin
        r_ds <= r_ds << ACC_WIDTH;
        r_ds[ACC_WIDTH-1:0] <= arr_b[j*ACC_WIDTH +: ACC_WIDTH];
      end
    end
    assign res_data[j*ACC_WIDTH +: ACC_WIDTH] = r_ds[(N-j)*ACC_WIDTH-1 -: ACC_WIDTH];
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: drives jobs into systolic_ctrl with a PE-grid array model and checks results against a matrix-vector reference
module tb_systolic_ctrl;
  localparam int N = 4, DW = 8, AW = 16, LW = 8, VW = N * DW;
  logic clk = 0, rst = 1, start = 0, keep_w = 0, w_valid = 0, a_valid = 0;
  logic [LW-1:0] m_len = '0;
  logic [VW-1:0] w_data = '0, a_data = '0;
  logic busy, done, w_ready, a_ready, res_valid;
  logic [N-1:0] arr_load;
  logic [VW-1:0] arr_wt, arr_a;
  logic [N*AW-1:0] arr_b, res_data;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, wr_cyc = 0, ar_cyc = 0, done_cnt = 0, res_cnt = 0;
  logic [DW-1:0] job_w [N][N];
  logic [DW-1:0] ref_w [N][N];
  logic [VW-1:0] vecs[$];
  typedef struct { int c; logic [N*AW-1:0] d; } exp_t;
  exp_t q[$];
  logic [DW-1:0] pw [N][N];
  logic [DW-1:0] pa [N][N];
  logic [AW-1:0] pp [N][N];
  always #5 clk = ~clk;
  systolic_ctrl #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .keep_w(keep_w), .m_len(m_len),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .arr_load(arr_load),
    .arr_wt(arr_wt), .arr_a(arr_a), .arr_b(arr_b), .res_valid(res_valid), .res_data(res_data)
  );
  // array environment: stationary weights, operands move right, partial sums move down
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (arr_load[i]) pw[i][j] <= arr_wt[j*DW +: DW];
        pa[i][j] <= j == 0 ? arr_a[i*DW +: DW] : pa[i][j-1];
        pp[i][j] <= (i == 0 ? AW'(0) : pp[i-1][j]) + AW'(j == 0 ? arr_a[i*DW +: DW] : pa[i][j-1]) * AW'(pw[i][j]);
      end
  end
  always_comb
    for (int j = 0; j < N; j++) arr_b[j*AW +: AW] = pp[N-1][j];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [N*AW-1:0] mvm(input logic [VW-1:0] a);
    logic [N*AW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) s += int'(a[i*DW +: DW]) * int'(ref_w[i][j]);
      r[j*AW +: AW] = AW'(s);
    end
    return r;
  endfunction
  // scoreboard: each accepted vector expects y = x*W exactly 2N+1 cycles after its accept edge
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (w_ready) wr_cyc++;
      if (a_ready) ar_cyc++;
      if (done) done_cnt++;
      if (a_valid && a_ready) q.push_back('{cyc + 1 + 2 * N, mvm(a_data)});
      while (q.size() > 0 && q[0].c < cyc) begin
        check("res_late", 64'(cyc), 64'(q[0].c));
        void'(q.pop_front());
      end
      if (res_valid) begin
        res_cnt++;
        check("res_expected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          check("res_time", 64'(cyc), 64'(q[0].c));
          check("res_data", 64'(res_data), 64'(q[0].d));
          void'(q.pop_front());
        end
      end
    end
  end
  task automatic check_idle_outputs(input string t);
    check({t, "_busy"}, 64'(busy), 64'd0);
    check({t, "_done"}, 64'(done), 64'd0);
    check({t, "_w_ready"}, 64'(w_ready), 64'd0);
    check({t, "_a_ready"}, 64'(a_ready), 64'd0);
    check({t, "_arr_load"}, 64'(arr_load), 64'd0);
    check({t, "_arr_wt"}, 64'(arr_wt), 64'd0);
    check({t, "_arr_a"}, 64'(arr_a), 64'd0);
    check({t, "_res_valid"}, 64'(res_valid), 64'd0);
    check({t, "_res_data"}, 64'(res_data), 64'd0);
  endtask
  task automatic run_job(input bit kw, input int len, input bit gaps, input int abort_at);
    int rows, sent, wr0, ar0, rs0, dn0;
    bit seen;
    rows = 0; sent = 0; seen = 0;
    wr0 = wr_cyc; ar0 = ar_cyc; rs0 = res_cnt; dn0 = done_cnt;
    if (!kw)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) ref_w[i][j] = job_w[i][j];
    start = 1; keep_w = kw; m_len = LW'(len);
    @(posedge clk); #1;
    start = 0; keep_w = 1'($urandom); m_len = LW'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    for (int c = 0; c < 400 && !seen; c++) begin
      if (abort_at >= 0 && sent >= abort_at) break;
      w_valid = !kw && rows < N && (!gaps || $urandom_range(0, 1) == 1);
      for (int j = 0; j < N; j++) w_data[j*DW +: DW] = job_w[rows % N][j];
      a_valid = sent < len && (!gaps || $urandom_range(0, 1) == 1);
      if (sent < len) a_data = vecs[sent];
      else a_data = VW'($urandom);
      @(negedge clk);
      if (w_valid && w_ready) rows++;
      if (a_valid && a_ready) sent++;
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    w_valid = 0; a_valid = 0;
    if (abort_at >= 0) begin
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check_idle_outputs("rst_mid");
      repeat (12) @(posedge clk);
      #1;
      check("no_done_after_abort", 64'(done_cnt - dn0), 64'd0);
      check("idle_after_abort", 64'(busy), 64'd0);
      return;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    check("res_count", 64'(res_cnt - rs0), 64'(len));
    check("res_pending", 64'(q.size()), 64'd0);
    if (kw) check("no_w_ready", 64'(wr_cyc - wr0), 64'd0);
    else check("rows_loaded", 64'(rows), 64'(N));
    if (len == 0) check("no_a_ready", 64'(ar_cyc - ar0), 64'd0);
  endtask
  task automatic set_w(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        job_w[i][j] = mode == 0 ? DW'(i == j) : mode == 1 ? DW'(2) : DW'($urandom);
  endtask
  initial begin
    int len;
    bit kw, w_ok;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 0;
    set_w(0); vecs = '{32'h04030201};
    run_job(0, 1, 0, -1);
    vecs = '{32'h08070605};
    run_job(1, 1, 0, -1);
    set_w(1); vecs = '{32'h01010101, 32'h02020202, 32'h05000000};
    run_job(0, 3, 0, -1);
    run_job(0, 3, 1, -1);
    set_w(2);
    run_job(0, 0, 0, -1);
    set_w(0); vecs = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10, 32'h11121314};
    run_job(0, 5, 0, 2);
    set_w(1); vecs = '{32'h01010101, 32'h02020202, 32'h05000000};
    run_job(0, 3, 1, -1);
    w_ok = 1;
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(0, 6);
      kw = w_ok && $urandom_range(0, 3) == 0;
      set_w(2);
      vecs.delete();
      for (int k = 0; k < len; k++) vecs.push_back(VW'($urandom));
      run_job(kw, len, 1'($urandom), -1);
    end
    repeat (20) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
